// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven 8-bit counter controller
// load / run / one-shot / stop / step with a clock prescaler
module counter_sequencer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic [1:0]       state,
  output logic             match,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_ONESHOT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_LOAD     = 3'd1,
    OP_PRESCALE = 3'd2,
    OP_LIMIT    = 3'd3,
    OP_RUN      = 3'd4,
    OP_ONESHOT  = 3'd5,
    OP_STOP     = 3'd6,
    OP_STEP     = 3'd7
  } op_t;

  state_t                st;
  op_t                   op;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] divider;
  logic [WIDTH-1:0]      limit;
  logic [WIDTH-1:0]      cnt_inc;
  logic                  accept;
  logic                  owns;
  logic                  step_ok;
  logic                  tick;
  logic                  hit;
  logic                  in_run;
  logic                  in_os;

  assign state = st;

  // Handshake, prescaler tick and next-count decode from registered state
  always_comb begin
    op      = op_t'(cmd_op);
    in_run  = (st == S_RUN);
    in_os   = (st == S_ONESHOT);
    busy    = in_run | in_os;
    cmd_ready = ena & ~in_os;
    accept  = cmd_valid & cmd_ready;
    tick    = busy & (divider == prescale);
    cnt_inc = cnt + WIDTH'(1);
    hit     = (cnt_inc == limit);
    owns    = 1'b0;
    step_ok = 1'b0;
    if (accept) begin
      unique case (1'b1)
        op == OP_LOAD,
        op == OP_PRESCALE,
        op == OP_RUN,
        op == OP_ONESHOT,
        op == OP_STOP: owns = 1'b1;
        op == OP_STEP: step_ok = ~busy;
        default: ;
      endcase
    end
  end

  // Sequencer: freeze > abort > counter-owning command > tick/step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      cnt      <= '0;
      prescale <= '0;
      limit    <= '1;
      divider  <= '0;
      match    <= 1'b0;
    end else if (!ena) begin
      match <= 1'b0;
    end else begin
      match <= 1'b0;
      if (in_os && abort) begin
        st <= S_IDLE;
      end else if (owns) begin
        unique case (op)
          OP_LOAD: begin
            cnt     <= cmd_data;
            divider <= '0;
          end
          OP_PRESCALE: begin
            prescale <= PRESCALE_W'(cmd_data);
            divider  <= '0;
          end
          OP_RUN: begin
            st      <= S_RUN;
            divider <= '0;
          end
          OP_ONESHOT: begin
            st      <= S_ONESHOT;
            divider <= '0;
          end
          OP_STOP: st <= S_IDLE;
          default: ;
        endcase
      end else begin
        if (accept && op == OP_LIMIT)
          limit <= cmd_data;
        if (step_ok) begin
          cnt   <= cnt_inc;
          match <= hit;
        end else if (busy) begin
          if (tick) begin
            divider <= '0;
            cnt     <= cnt_inc;
            match   <= hit;
            if (in_os && hit)
              st <= S_DONE;
          end else begin
            divider <= divider + PRESCALE_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed checks of counter_sequencer
// inputs driven and outputs sampled on the falling edge
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       abort;
  logic [7:0] cnt;
  logic [1:0] state;
  logic       match;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] PRE  = 3'd2;
  localparam logic [2:0] LIM  = 3'd3;
  localparam logic [2:0] RUN  = 3'd4;
  localparam logic [2:0] ONE  = 3'd5;
  localparam logic [2:0] STOP = 3'd6;
  localparam logic [2:0] STEP = 3'd7;

  counter_sequencer #(.WIDTH(8), .PRESCALE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .cnt       (cnt),
    .state     (state),
    .match     (match),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present a command at the current falling edge for one cycle
  task automatic cmd(logic [2:0] op, logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 8'd0;
  endtask

  task automatic cyc(int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_data = 8'd0;
    abort = 1'b0;

    @(negedge clk);
    check("rst_cnt", cnt, 0);
    check("rst_state", state, 0);
    check("rst_match", match, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Free run at full rate, then stop
    cmd(LOAD, 8'h10);
    check("load_cnt", cnt, 8'h10);
    cmd(RUN, 8'h00);
    check("run_state", state, 1);
    check("run_busy", busy, 1);
    check("run_cnt0", cnt, 8'h10);
    cyc(1);
    check("run_cnt1", cnt, 8'h11);
    cyc(1);
    check("run_cnt2", cnt, 8'h12);
    cmd(STOP, 8'h00);
    check("stop_cnt", cnt, 8'h12);
    check("stop_state", state, 0);
    cyc(2);
    check("stop_hold", cnt, 8'h12);

    // Prescale 3: one increment per 4 cycles
    cmd(PRE, 8'd3);
    cmd(LOAD, 8'h00);
    cmd(RUN, 8'h00);
    cyc(3);
    check("pre_before", cnt, 0);
    cyc(1);
    check("pre_first", cnt, 1);
    cyc(3);
    check("pre_mid", cnt, 1);
    cyc(1);
    check("pre_second", cnt, 2);
    cmd(STOP, 8'h00);
    cmd(PRE, 8'd0);

    // One-shot to limit 5 from 2
    cmd(LIM, 8'h05);
    cmd(LOAD, 8'h02);
    cmd(ONE, 8'h00);
    check("os_state", state, 2);
    check("os_ready", cmd_ready, 0);
    cyc(1);
    check("os_c3", cnt, 3);
    check("os_m3", match, 0);
    cyc(1);
    check("os_c4", cnt, 4);
    cyc(1);
    check("os_c5", cnt, 5);
    check("os_match", match, 1);
    check("os_done", state, 3);
    check("os_busy", busy, 0);
    cyc(1);
    check("os_mclr", match, 0);
    check("os_hold", cnt, 5);
    check("done_ready", cmd_ready, 1);
    cmd(STEP, 8'h00);
    check("step_cnt", cnt, 6);
    check("step_match", match, 0);
    check("step_state", state, 3);

    // Wrap through limit 0 while running
    cmd(LOAD, 8'hFE);
    cmd(LIM, 8'h00);
    cmd(RUN, 8'h00);
    check("wr_c0", cnt, 8'hFE);
    cyc(1);
    check("wr_cff", cnt, 8'hFF);
    check("wr_mff", match, 0);
    cyc(1);
    check("wr_c00", cnt, 8'h00);
    check("wr_m00", match, 1);
    cyc(1);
    check("wr_c01", cnt, 8'h01);
    check("wr_m01", match, 0);
    check("wr_state", state, 1);
    cmd(STOP, 8'h00);

    // Abort a one-shot mid-count
    cmd(LIM, 8'h80);
    cmd(LOAD, 8'h00);
    cmd(ONE, 8'h00);
    cyc(32);
    check("ab_pre", cnt, 8'h20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_state", state, 0);
    check("ab_cnt", cnt, 8'h20);
    check("ab_match", match, 0);
    cyc(2);
    check("ab_hold", cnt, 8'h20);

    // Asynchronous reset mid one-shot
    cmd(LOAD, 8'h00);
    cmd(ONE, 8'h00);
    cyc(3);
    check("ar_pre", cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_cnt", cnt, 0);
    check("ar_state", state, 0);
    check("ar_busy", busy, 0);
    check("ar_match", match, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Enable freeze keeps divider phase (prescale 2)
    cmd(PRE, 8'd2);
    cmd(LOAD, 8'h00);
    cmd(RUN, 8'h00);
    cyc(3);
    check("en_c1", cnt, 1);
    cyc(1);
    ena = 1'b0;
    #1;
    check("en_ready", cmd_ready, 0);
    cyc(5);
    check("en_frz_cnt", cnt, 1);
    check("en_frz_st", state, 1);
    ena = 1'b1;
    cyc(1);
    check("en_res1", cnt, 1);
    cyc(1);
    check("en_res2", cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
